// File: rtl/multi_combiner_pkg.sv
// Shared constants and helpers for the N-channel stream join.
// Holds the BURST mode strings, the skid depth function and the default counter width.
package multi_combiner_pkg;

    localparam string BURST_YES    = "yes";
    localparam string BURST_NO     = "no";
    localparam int    DEFAULT_CNTW = 16;

    // Two entries give full throughput; one entry halves it.
    function automatic int skidDepth(input string burst);
        return (burst == BURST_YES) ? 2 : 1;
    endfunction

endpackage

// File: rtl/multi_combiner_chan_skid.sv
// Per-channel skid buffer (1 or 2 entries, FIFO order, head = older entry).
// Ports: iCLK/iRST, iValid/oReady push side, iData, oNotEmpty/oHead/iPop pop side.
module chan_skid
    import multi_combiner_pkg::*;
#(
    parameter int    WIDTH = 8,
    parameter string BURST = BURST_YES
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iValid,
    output logic             oReady,
    input  logic [WIDTH-1:0] iData,
    output logic             oNotEmpty,
    output logic [WIDTH-1:0] oHead,
    input  logic             iPop
);

    localparam int DEPTH = skidDepth(BURST);

    logic [1:0]       count;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic             push;
    logic             pop;

    // Ready depends only on registered state, forced low during reset.
    always_comb begin
        oReady = 1'b0;
        if (!iRST) begin
            if (DEPTH == 2) begin
                oReady = (count < 2'd2);
            end else begin
                oReady = (count == 2'd0);
            end
        end
    end

    assign push      = iValid & oReady;
    assign pop       = iPop & (count != 2'd0);
    assign oNotEmpty = (count != 2'd0);
    assign oHead     = head;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head <= iData;
                    end else begin
                        tail <= iData;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    // Clearing the vacated slot keeps an empty head at zero.
                    head  <= tail;
                    tail  <= '0;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // New beat lands behind whatever remains after the pop.
                    if (count == 2'd1) begin
                        head <= iData;
                    end else begin
                        head <= tail;
                        tail <= iData;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/multi_combiner.sv
// N-channel stream join: one beat from every enabled channel forms one output beat.
// Ports: iValid_AM/oReady_AM/iData_AM inputs, iMask, oValid_BM/iReady_BM/oData_BM output, oCount.
module multi_combiner
    import multi_combiner_pkg::*;
#(
    parameter int    CHANNELS = 4,
    parameter int    WIDTH    = 8,
    parameter string BURST    = BURST_YES,
    parameter int    CNTW     = DEFAULT_CNTW
) (
    input  logic                      iCLK,
    input  logic                      iRST,
    input  logic [CHANNELS-1:0]       iValid_AM,
    output logic [CHANNELS-1:0]       oReady_AM,
    input  logic [CHANNELS*WIDTH-1:0] iData_AM,
    input  logic [CHANNELS-1:0]       iMask,
    output logic                      oValid_BM,
    input  logic                      iReady_BM,
    output logic [CHANNELS*WIDTH-1:0] oData_BM,
    output logic [CNTW-1:0]           oCount
);

    logic [CHANNELS-1:0]       notEmpty;
    logic [CHANNELS-1:0]       avail;
    logic [CHANNELS-1:0]       pop;
    logic [CHANNELS*WIDTH-1:0] heads;
    logic                      fire;

    for (genvar i = 0; i < CHANNELS; i++) begin : gChan
        chan_skid #(
            .WIDTH (WIDTH),
            .BURST (BURST)
        ) uSkid (
            .iCLK      (iCLK),
            .iRST      (iRST),
            .iValid    (iValid_AM[i]),
            .oReady    (oReady_AM[i]),
            .iData     (iData_AM[i*WIDTH +: WIDTH]),
            .oNotEmpty (notEmpty[i]),
            .oHead     (heads[i*WIDTH +: WIDTH]),
            .iPop      (pop[i])
        );

        // A masked channel never blocks the join and contributes zeros.
        assign avail[i] = notEmpty[i] | ~iMask[i];
        assign oData_BM[i*WIDTH +: WIDTH] =
            iMask[i] ? heads[i*WIDTH +: WIDTH] : '0;
    end

    assign oValid_BM = ~iRST & (&avail) & (|iMask);
    assign fire      = oValid_BM & iReady_BM;
    assign pop       = {CHANNELS{fire}} & iMask;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oCount <= '0;
        end else if (fire) begin
            oCount <= oCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_multi_combiner.sv
// Scoreboard bench for multi_combiner (4x8-bit burst DUT plus a non-burst DUT).
// Per-channel queues model the skids; outputs are compared every cycle.
module tb_multi_combiner;

    localparam int CH = 4;
    localparam int W  = 8;
    localparam int CW = 4;

    logic            clk   = 1'b0;
    logic            rst   = 1'b1;
    logic [CH-1:0]   valid = '0;
    logic [CH-1:0]   mask  = '0;
    logic [CH*W-1:0] data  = '0;
    logic            rdy   = 1'b0;

    logic [CH-1:0]   readyA;
    logic            validA;
    logic [CH*W-1:0] dataA;
    logic [CW-1:0]   countA;

    logic [CH-1:0]   readyN;
    logic            validN;
    logic [CH*W-1:0] dataN;
    logic [15:0]     countN;

    always #5 clk = ~clk;

    multi_combiner #(
        .CHANNELS (CH),
        .WIDTH    (W),
        .BURST    ("yes"),
        .CNTW     (CW)
    ) dut (
        .iCLK      (clk),
        .iRST      (rst),
        .iValid_AM (valid),
        .oReady_AM (readyA),
        .iData_AM  (data),
        .iMask     (mask),
        .oValid_BM (validA),
        .iReady_BM (rdy),
        .oData_BM  (dataA),
        .oCount    (countA)
    );

    multi_combiner #(
        .CHANNELS (CH),
        .WIDTH    (W),
        .BURST    ("no"),
        .CNTW     (16)
    ) dutN (
        .iCLK      (clk),
        .iRST      (rst),
        .iValid_AM (valid),
        .oReady_AM (readyN),
        .iData_AM  (data),
        .iMask     (mask),
        .oValid_BM (validN),
        .iReady_BM (rdy),
        .oData_BM  (dataN),
        .oCount    (countN)
    );

    int nVec = 0;
    int nMis = 0;
    int expCount = 0;
    int firesA = 0;
    int firesN = 0;
    logic [W-1:0] chQ [CH][$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nMis++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [W-1:0] d);
        valid[c] = 1'b1;
        data[c*W +: W] = d;
        step();
        valid[c] = 1'b0;
    endtask

    // Scoreboard monitor: compare, then advance the model for the next edge.
    always @(negedge clk) begin
        logic [CH-1:0]   expRdy;
        logic            expVal;
        logic [CH*W-1:0] expData;
        if (validA && rdy) firesA++;
        if (validN && rdy) firesN++;
        if (rst) begin
            chk("rstReady", 32'(readyA), 32'h0);
            chk("rstValid", 32'(validA), 32'h0);
            chk("rstValidN", 32'(validN), 32'h0);
            for (int c = 0; c < CH; c++) chQ[c].delete();
            expCount = 0;
        end else begin
            expVal  = |mask;
            expData = '0;
            for (int c = 0; c < CH; c++) begin
                expRdy[c] = (chQ[c].size() < 2);
                if (mask[c]) begin
                    if (chQ[c].size() == 0) expVal = 1'b0;
                    else expData[c*W +: W] = chQ[c][0];
                end
            end
            chk("ready", 32'(readyA), 32'(expRdy));
            chk("valid", 32'(validA), 32'(expVal));
            chk("count", 32'(countA), 32'(expCount[CW-1:0]));
            if (expVal) chk("data", dataA, expData);
            if (expVal && rdy) begin
                for (int c = 0; c < CH; c++)
                    if (mask[c]) void'(chQ[c].pop_front());
                expCount = (expCount + 1) % (1 << CW);
            end
            for (int c = 0; c < CH; c++)
                if (valid[c] && expRdy[c]) chQ[c].push_back(data[c*W +: W]);
        end
    end

    // Upstream protocol: mask must not move while the output is stalled.
    logic [CH-1:0] maskPrev = '0;
    logic          holdPrev = 1'b0;
    always @(posedge clk) begin
        if (holdPrev)
            assert (mask == maskPrev)
            else $error("iMask changed while output stalled");
        holdPrev <= validA & ~rdy & ~rst;
        maskPrev <= mask;
    end

    initial begin
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("postRstReady", 32'(readyA), 32'hf);
        chk("postRstValid", 32'(validA), 32'h0);
        chk("postRstData", dataA, 32'h0);
        chk("postRstCount", 32'(countA), 32'h0);

        // Basic two-channel join
        mask = 4'b0011;
        rdy  = 1'b1;
        step();
        push(0, 8'h0a);
        push(1, 8'h0b);
        @(negedge clk);
        chk("joinValid", 32'(validA), 32'h1);
        chk("joinData", dataA, 32'h00000b0a);
        step();
        @(negedge clk);
        chk("joinOnce", 32'(validA), 32'h0);
        chk("joinCount", 32'(countA), 32'h1);
        chk("joinReady", 32'(readyA), 32'hf);

        // Backpressure
        rdy = 1'b0;
        push(0, 8'h07);
        push(0, 8'h01);
        @(negedge clk);
        chk("bpFull", 32'(readyA[0]), 32'h0);
        push(0, 8'h02);
        push(1, 8'h08);
        @(negedge clk);
        chk("bpData", dataA, 32'h00000807);
        step();
        step();
        @(negedge clk);
        chk("bpHold", dataA, 32'h00000807);
        rdy = 1'b1;
        step();
        @(negedge clk);
        chk("bpWait", 32'(validA), 32'h0);
        push(1, 8'h09);
        @(negedge clk);
        chk("bpSecond", dataA, 32'h00000901);
        step();

        // Mask
        mask  = 4'b0101;
        valid = 4'b0111;
        data  = 32'h00051103;
        step();
        valid = '0;
        @(negedge clk);
        chk("maskData", dataA, 32'h00050003);
        step();
        mask = 4'b0000;
        push(3, 8'h31);
        push(3, 8'h32);
        @(negedge clk);
        chk("mask0Valid", 32'(validA), 32'h0);
        chk("mask0Full", 32'(readyA[3]), 32'h0);
        mask  = 4'b1111;
        valid = 4'b0101;
        data  = 32'h00420041;
        step();
        valid = '0;
        @(negedge clk);
        chk("maskJoin", dataA, 32'h31421141);
        step();

        // Reset mid-flight
        mask = 4'b0000;
        push(2, 8'h51);
        push(2, 8'h52);
        rst = 1'b1;
        step();
        rst  = 1'b0;
        mask = 4'b1111;
        @(negedge clk);
        chk("midRstCount", 32'(countA), 32'h0);
        chk("midRstData", dataA, 32'h0);
        chk("midRstReady", 32'(readyA), 32'hf);
        valid = 4'b1011;
        data  = 32'h64006261;
        step();
        valid = '0;
        @(negedge clk);
        chk("noStale", 32'(validA), 32'h0);
        push(2, 8'h63);
        @(negedge clk);
        chk("freshData", dataA, 32'h64636261);
        step();

        // Throughput, both depths, from a clean reset
        rst = 1'b1;
        step();
        rst    = 1'b0;
        firesA = 0;
        firesN = 0;
        valid  = 4'hf;
        for (int i = 0; i < 100; i++) begin
            for (int c = 0; c < CH; c++)
                data[c*W +: W] = W'(i + 16 * c);
            step();
        end
        valid = '0;
        chk("thrBurst", 32'(firesA >= 99), 32'h1);
        chk("thrNoBurst", 32'(firesN >= 49 && firesN <= 51), 32'h1);
        chk("cntNoBurst", 32'(countN), 32'(firesN));
        step();
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/multi_combiner.md
Name: multi_combiner

Overview:
N-channel stream join, the parametrised successor of the two-input combiner. Each of CHANNELS valid/ready inputs is buffered in its own skid stage. One beat from every enabled channel is concatenated into a single output beat. A runtime channel mask and a completed-beat counter are included. The block sits between independent per-lane producers (PE outputs, weight/activation streams) and a wide downstream consumer.

Parameters:
CHANNELS, 4, number of input streams (>=2)
WIDTH, 8, data bits per channel
BURST, "yes", "yes": 2-entry skid per channel, full throughput; "no": 1-entry, one beat per 2 cycles
CNTW, 16, width of completed-beat counter

Ports:
iCLK  in  1  clock, all logic on rising edge
iRST  in  1  synchronous active-high reset
iValid_AM  in  CHANNELS  per-channel input valid
oReady_AM  out  CHANNELS  per-channel input ready
iData_AM  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
iMask  in  CHANNELS  1 = channel participates in join
oValid_BM  out  1  output valid
iReady_BM  in  1  output ready
oData_BM  out  CHANNELS*WIDTH  concatenated heads, same slicing as input
oCount  out  CNTW  number of output beats transferred, wraps

Behaviour:
- Reset (iRST=1 at an edge): all skid counts = 0, all entries = 0, oCount = 0.
- While iRST=1: oReady_AM = 0 and oValid_BM = 0 (combinational force); pushes ignored.
- First cycle after reset: oReady_AM = all ones, oValid_BM = 0, oData_BM = 0.
- Per channel: push_i = iValid_AM[i] & oReady_AM[i]. Depth D = 2 (BURST="yes") or 1 (BURST="no").
- oReady_AM[i] = (count_i < D) when BURST="yes", and (count_i == 0) when BURST="no".
- oReady_AM is a function of registered state only; it must not depend combinationally on iReady_BM.
- Skid order is FIFO. The head is the older entry.
- Push and pop in the same cycle: count unchanged; the new beat enqueues behind the head.
- avail_i = (count_i > 0) | ~iMask[i].
- oValid_BM = &avail & (|iMask).
- iMask = 0: oValid_BM = 0. Inputs are still buffered until full.
- oData_BM slice i = head_i if iMask[i], else 0.
- fire = oValid_BM & iReady_BM. On fire, every enabled channel pops exactly one beat. Masked channels are untouched.
- Latency: a beat pushed at edge k is visible on oData_BM in the cycle after edge k, provided all other enabled channels are non-empty.
- Throughput: with BURST="yes" and iReady_BM held high, one beat per cycle sustained. With BURST="no", one beat per 2 cycles.
- Stability: once oValid_BM=1 and iReady_BM=0, oValid_BM and oData_BM hold until fire. This holds because no pop occurs and pushes only append.
- Upstream must keep iMask stable while oValid_BM & ~iReady_BM. Violating this is a protocol error; the bench asserts on it.
- oCount increments by 1 on each fire, wrapping (2^CNTW - 1) -> 0. It holds otherwise.
- Reset asserted mid-operation discards all buffered beats. No partial output beat is produced.

Decomposition:
- Shared package: BURST string constants, depth function from BURST, default CNTW.
- Sub-module chan_skid, instantiated CHANNELS times by generate.
  - Parameters: WIDTH, BURST.
  - Ports: iCLK, iRST, iValid, oReady, iData, oNotEmpty, oHead, iPop.
- Top level contains only the avail AND-reduction, masking mux and counter.

Test Plan:
- Join basic (CHANNELS=2, WIDTH=4, mask=2'b11, iReady_BM=1): ch0=4'ha at cycle 1, ch1=4'hb at cycle 2 -> oValid_BM=1 for exactly one cycle, oData_BM=8'hba, oCount=1; both oReady_AM high afterwards.
- Backpressure (iReady_BM=0, BURST="yes"): ch0 pushes 7, 1, 2, ch1 pushes 8 -> oReady_AM[0]=0 after two beats; oData_BM=8'h87 held stable. On iReady_BM=1: beats 8'h87 delivered; then 8'hx1 waits until ch1 supplies a second beat.
- Mask (CHANNELS=4, iMask=4'b0101): ch0=3 and ch2=5 pushed, ch1/ch3 idle -> oData_BM=32'h00050003 (WIDTH=8 slicing); ch1/ch3 buffers untouched; iMask=0 -> oValid_BM=0.
- Throughput: BURST="yes", all valids high for 100 cycles with iReady_BM=1 -> 99 or more fires with an incrementing-pattern data check. BURST="no" -> exactly 50 fires ±1.
- Counter wrap (CNTW=4): 17 fires -> oCount sequence ...15, 0, 1.
- Reset mid-flight: one channel holding 2 beats, iRST pulsed 1 cycle -> during reset oReady_AM=0 and oValid_BM=0. After reset: counts 0, oData_BM=0, oCount=0, no stale beat ever output.
